pl_reg_idex: RTL

- Decode-to-execute pipeline register; the producer end of the execute-stage operand interface (ea, eb, epc4, ealuc, ecall).
- Captures decoded operands and ALU control from the ID stage and presents them registered to the execute stage.
- Uses a valid/ready handshake on both sides and a 2-entry skid buffer, so upstream ready is fully registered and no bubbles appear under back-pressure.
- Supports pipeline flush for branch/trap redirect and keeps a saturating stall-cycle counter.

---
 rtl/pl_pkg.sv | 43 ++++
 rtl/pl_skid_buf.sv | 86 ++++++++
 rtl/pl_reg_idex.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pl_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU op codes,
// payload layout and skid-buffer state encoding.
package pl_pkg;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SLL    = 5'b00101;
    localparam logic [4:0] ALU_SRL    = 5'b00110;
    localparam logic [4:0] ALU_SRA    = 5'b00111;
    localparam logic [4:0] ALU_SLT    = 5'b01000;
    localparam logic [4:0] ALU_SLTU   = 5'b01001;
    localparam logic [4:0] ALU_LUI    = 5'b01010;
    localparam logic [4:0] ALU_MUL    = 5'b01011;
    localparam logic [4:0] ALU_MULH   = 5'b01100;
    localparam logic [4:0] ALU_DIV    = 5'b01101;
    localparam logic [4:0] ALU_DIVU   = 5'b01110;
    localparam logic [4:0] ALU_REM    = 5'b01111;
    localparam logic [4:0] ALU_REMU   = 5'b10000;
    localparam logic [4:0] ALU_INC    = 5'b10001;
    localparam logic [4:0] ALU_DEC    = 5'b10010;
    localparam logic [4:0] ALU_OP_MAX = ALU_DEC;

    // Default operand/PC width of the decode-to-execute payload.
    localparam int PL_DATA_WIDTH = 64;

    typedef struct packed {
        logic [PL_DATA_WIDTH-1:0] a;
        logic [PL_DATA_WIDTH-1:0] b;
        logic [PL_DATA_WIDTH-1:0] pc4;
        logic [4:0]               aluc;
        logic                     call;
    } idex_payload_t;

    typedef enum logic [1:0] {
        IDX_EMPTY = 2'd0,
        IDX_FULL  = 2'd1,
        IDX_SKID  = 2'd2
    } idx_state_e;

endpackage

// File: rtl/pl_skid_buf.sv
// Generic 2-entry skid buffer: a main register driving the outputs plus
// one skid register. Upstream ready depends only on registered state, so
// there is no combinational path from out_ready to in_ready.
module pl_skid_buf
    import pl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    idx_state_e       state_p1;
    logic [WIDTH-1:0] main_p1;
    logic [WIDTH-1:0] skid_p1;
    logic             vld_p1;
    logic             rdy_p1;
    logic             acc;
    logic             cons;

    assign acc       = in_valid && rdy_p1;
    assign cons      = vld_p1 && out_ready;
    assign in_ready  = rdy_p1;
    assign out_valid = vld_p1;
    assign out_data  = main_p1;

    // Stage p1: buffer FSM; flush beats every other event, reset holds ready low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= IDX_EMPTY;
            main_p1  <= '0;
            skid_p1  <= '0;
            vld_p1   <= 1'b0;
            rdy_p1   <= 1'b0;
        end else if (flush) begin
            state_p1 <= IDX_EMPTY;
            main_p1  <= '0;
            skid_p1  <= '0;
            vld_p1   <= 1'b0;
            rdy_p1   <= 1'b1;
        end else begin
            case (state_p1)
                IDX_EMPTY: begin
                    rdy_p1 <= 1'b1;
                    if (acc) begin
                        main_p1  <= in_data;
                        vld_p1   <= 1'b1;
                        state_p1 <= IDX_FULL;
                    end
                end
                IDX_FULL: begin
                    if (acc && cons) begin
                        main_p1 <= in_data;
                    end else if (cons) begin
                        vld_p1   <= 1'b0;
                        state_p1 <= IDX_EMPTY;
                    end else if (acc) begin
                        skid_p1  <= in_data;
                        rdy_p1   <= 1'b0;
                        state_p1 <= IDX_SKID;
                    end
                end
                IDX_SKID: begin
                    if (cons) begin
                        main_p1  <= skid_p1;
                        rdy_p1   <= 1'b1;
                        state_p1 <= IDX_FULL;
                    end
                end
                default: begin
                    state_p1 <= IDX_EMPTY;
                    vld_p1   <= 1'b0;
                    rdy_p1   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pl_reg_idex.sv
// Decode-to-execute pipeline register built on a 2-entry skid buffer,
// with flush and a saturating stall-cycle counter.
// Optional feature macro: PL_IDEX_OPCHECK_EN (illegal ALU op check and
// illegal_op pulse output).
module pl_reg_idex
    import pl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [DATA_WIDTH-1:0] d_a,
    input  logic [DATA_WIDTH-1:0] d_b,
    input  logic [DATA_WIDTH-1:0] d_pc4,
    input  logic [4:0]            d_aluc,
    input  logic                  d_call,
    output logic                  e_valid,
    input  logic                  e_ready,
    output logic [DATA_WIDTH-1:0] ea,
    output logic [DATA_WIDTH-1:0] eb,
    output logic [DATA_WIDTH-1:0] epc4,
    output logic [4:0]            ealuc,
    output logic                  ecall,
    output logic [CNT_WIDTH-1:0]  stall_cnt
`ifdef PL_IDEX_OPCHECK_EN
    ,
    output logic                  illegal_op
`endif
);

    // Payload carried through the buffer; width follows DATA_WIDTH.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] pc4;
        logic [4:0]            aluc;
        logic                  call;
`ifdef PL_IDEX_OPCHECK_EN
        logic                  ill;
`endif
    } payload_t;

    localparam int PW = $bits(payload_t);

    payload_t             in_pl_p0;
    payload_t             out_pl_p1;
    logic [CNT_WIDTH-1:0] stall_p1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Stage p0: assemble the incoming payload, sanitising illegal ops when enabled.
    always_comb begin
        in_pl_p0      = '0;
        in_pl_p0.a    = d_a;
        in_pl_p0.b    = d_b;
        in_pl_p0.pc4  = d_pc4;
        in_pl_p0.call = d_call;
`ifdef PL_IDEX_OPCHECK_EN
        in_pl_p0.ill  = (d_aluc > ALU_OP_MAX);
        in_pl_p0.aluc = (d_aluc > ALU_OP_MAX) ? ALU_ADD : d_aluc;
`else
        in_pl_p0.aluc = d_aluc;
`endif
    end

    pl_skid_buf #(
        .WIDTH (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (d_valid),
        .in_ready  (d_ready),
        .in_data   (in_pl_p0),
        .out_valid (e_valid),
        .out_ready (e_ready),
        .out_data  (out_pl_p1)
    );

    assign ea        = out_pl_p1.a;
    assign eb        = out_pl_p1.b;
    assign epc4      = out_pl_p1.pc4;
    assign ealuc     = out_pl_p1.aluc;
    assign ecall     = out_pl_p1.call;
    assign stall_cnt = stall_p1;

    // Stage p1: count stalled output cycles; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_p1 <= '0;
        end else if (e_valid && !e_ready) begin
            stall_p1 <= sat_inc(stall_p1);
        end
    end

`ifdef PL_IDEX_OPCHECK_EN
    logic shown_p1;

    // Stage p1: remember that the current output entry was already presented,
    // so a held illegal entry pulses illegal_op only on its first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown_p1 <= 1'b0;
        end else if (flush) begin
            shown_p1 <= 1'b0;
        end else begin
            shown_p1 <= e_valid && !e_ready;
        end
    end

    assign illegal_op = e_valid && out_pl_p1.ill && !shown_p1;
`endif

endmodule
